// File: rtl/phy_link_monitor.sv
// Per-lane 10GBASE-R link qualifier: synchronises PHY status, debounces link-up,
// counts drops and hi-BER events, and shows one lane's drop count on two 7-segment digits.
//
//  state | meaning
//  DOWN  | link not good, waiting for good status
//  QUAL  | status good, qualification timer running
//  UP    | link qualified, link_up asserted
module phy_link_monitor #(
    parameter int LANES       = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int UP_TIME     = 156250,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES-1:0]     rx_block_lock,
    input  logic [LANES-1:0]     rx_hi_ber,
    input  logic                 clear,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [LANES-1:0]     link_up,
    output logic [LANES-1:0]     link_change,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] ber_count,
    output logic [6:0]           hex0_d,
    output logic [6:0]           hex1_d,
    output logic                 hex_dp
);

    localparam int TW = (UP_TIME > 1) ? $clog2(UP_TIME) : 1;

    typedef enum logic [1:0] {DOWN, QUAL, UP} state_e;

    logic [LANES-1:0]     lock_sync [SYNC_STAGES];
    logic [LANES-1:0]     ber_sync  [SYNC_STAGES];
    logic [LANES-1:0]     ber_s_d;
    logic [LANES-1:0]     lock_s;
    logic [LANES-1:0]     ber_s;
    logic [LANES-1:0]     good;
    state_e               state     [LANES];
    logic [TW-1:0]        timer     [LANES];
    logic [CNT_WIDTH-1:0] drop_cnt  [LANES];
    logic [CNT_WIDTH-1:0] ber_cnt   [LANES];
    logic [SEL_WIDTH-1:0] sel_idx;

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign ber_s  = ber_sync[SYNC_STAGES-1];
    assign good   = lock_s & ~ber_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                lock_sync[s] <= '0;
                ber_sync[s]  <= '0;
            end
        end else begin
            lock_sync[0] <= rx_block_lock;
            ber_sync[0]  <= rx_hi_ber;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                lock_sync[s] <= lock_sync[s-1];
                ber_sync[s]  <= ber_sync[s-1];
            end
        end
    end

    // Timer counts down from UP_TIME-1; terminal count 0 promotes QUAL to UP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= '0;
            link_change <= '0;
            ber_s_d     <= '0;
            for (int i = 0; i < LANES; i++) begin
                state[i]    <= DOWN;
                timer[i]    <= '0;
                drop_cnt[i] <= '0;
                ber_cnt[i]  <= '0;
            end
        end else begin
            ber_s_d     <= ber_s;
            link_change <= '0;
            for (int i = 0; i < LANES; i++) begin
                case (state[i])
                    DOWN: begin
                        if (good[i]) begin
                            state[i] <= QUAL;
                            timer[i] <= TW'(UP_TIME - 1);
                        end
                    end
                    QUAL: begin
                        if (!good[i]) begin
                            state[i] <= DOWN;
                        end else if (timer[i] == '0) begin
                            state[i]       <= UP;
                            link_up[i]     <= 1'b1;
                            link_change[i] <= 1'b1;
                        end else begin
                            timer[i] <= timer[i] - 1'b1;
                        end
                    end
                    UP: begin
                        if (!good[i]) begin
                            state[i]       <= DOWN;
                            link_up[i]     <= 1'b0;
                            link_change[i] <= 1'b1;
                            if (drop_cnt[i] != '1)
                                drop_cnt[i] <= drop_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i]   <= DOWN;
                        link_up[i] <= 1'b0;
                    end
                endcase
                if (ber_s[i] && !ber_s_d[i] && ber_cnt[i] != '1)
                    ber_cnt[i] <= ber_cnt[i] + 1'b1;
                // clear overrides any increment made above in the same cycle
                if (clear) begin
                    drop_cnt[i] <= '0;
                    ber_cnt[i]  <= '0;
                end
            end
        end
    end

    assign sel_idx    = (int'(sel) < LANES) ? sel : '0;
    assign drop_count = drop_cnt[sel_idx];
    assign ber_count  = ber_cnt[sel_idx];

    function automatic logic [6:0] seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h3F;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex0_d <= 7'h3F;
            hex1_d <= 7'h3F;
            hex_dp <= 1'b0;
        end else begin
            hex0_d <= seg(drop_count[3:0]);
            hex1_d <= seg(drop_count[7:4]);
            hex_dp <= link_up[sel_idx];
        end
    end

endmodule

// File: tb/tb_phy_link_monitor.sv
// Directed bench for phy_link_monitor with UP_TIME=16, SYNC_STAGES=2, four lanes.
module tb_phy_link_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rx_block_lock = '0;
    logic [3:0] rx_hi_ber = '0;
    logic       clear = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] link_up;
    logic [3:0] link_change;
    logic [7:0] drop_count;
    logic [7:0] ber_count;
    logic [6:0] hex0_d;
    logic [6:0] hex1_d;
    logic       hex_dp;

    int checks = 0;
    int failures = 0;
    int chg_cnt [4] = '{0, 0, 0, 0};

    phy_link_monitor #(
        .LANES(4), .SEL_WIDTH(2), .SYNC_STAGES(2), .UP_TIME(16), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_block_lock(rx_block_lock), .rx_hi_ber(rx_hi_ber),
        .clear(clear), .sel(sel), .link_up(link_up), .link_change(link_change),
        .drop_count(drop_count), .ber_count(ber_count), .hex0_d(hex0_d), .hex1_d(hex1_d),
        .hex_dp(hex_dp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++)
                if (link_change[i]) chg_cnt[i]++;
        end
    end

    typedef struct {
        logic [1:0] sel;
        logic [7:0] drop;
        logic [7:0] ber;
        logic [6:0] hex0;
        logic [6:0] hex1;
        logic       dp;
    } vec_t;

    vec_t vecs [4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_link_up"}, link_up, 0);
        check({tag, "_link_change"}, link_change, 0);
        check({tag, "_hex0"}, hex0_d, 7'h3F);
        check({tag, "_hex1"}, hex1_d, 7'h3F);
        check({tag, "_hex_dp"}, hex_dp, 0);
        check({tag, "_drop"}, drop_count, 0);
        check({tag, "_ber"}, ber_count, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            vecs[i] = '{sel: 2'(i), drop: 8'd5, ber: 8'(i + 1), hex0: 7'h6D, hex1: 7'h3F, dp: 1'b1};

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // 1: lane 0 qualifies after 19 edges
        rx_block_lock[0] = 1'b1;
        tick(18);
        check("t1_not_yet", link_up, 4'b0000);
        tick(1);
        check("t1_up", link_up, 4'b0001);
        check("t1_change", link_change, 4'b0001);
        tick(1);
        check("t1_change_gone", link_change, 4'b0000);
        check("t1_change_count", chg_cnt[0], 1);

        // 2: lane 1 up, drop for 5 cycles, relink
        sel = 2'd1;
        rx_block_lock[1] = 1'b1;
        tick(19);
        check("t2_up", link_up, 4'b0011);
        rx_block_lock[1] = 1'b0;
        tick(2);
        check("t2_still_up", link_up[1], 1);
        tick(1);
        check("t2_fell", link_up[1], 0);
        check("t2_drop", drop_count, 1);
        tick(1);
        check("t2_hex0", hex0_d, 7'h06);
        check("t2_hex1", hex1_d, 7'h3F);
        tick(1);
        rx_block_lock[1] = 1'b1;
        tick(18);
        check("t2_relink_early", link_up[1], 0);
        tick(1);
        check("t2_relink", link_up[1], 1);
        tick(1);
        check("t2_hex_dp", hex_dp, 1);

        // 3: glitch during qualification restarts it
        sel = 2'd2;
        rx_block_lock[2] = 1'b1;
        tick(10);
        rx_block_lock[2] = 1'b0;
        tick(3);
        check("t3_no_up", link_up[2], 0);
        check("t3_no_drop", drop_count, 0);
        rx_block_lock[2] = 1'b1;
        tick(18);
        check("t3_not_yet", link_up[2], 0);
        tick(1);
        check("t3_up", link_up[2], 1);

        // 4: saturate lane 3 drop and ber counters
        for (int k = 0; k < 260; k++) begin
            rx_block_lock[3] = 1'b1;
            tick(19);
            rx_block_lock[3] = 1'b0;
            tick(3);
        end
        for (int k = 0; k < 300; k++) begin
            rx_hi_ber[3] = 1'b1;
            tick(1);
            rx_hi_ber[3] = 1'b0;
            tick(1);
        end
        tick(3);
        sel = 2'd3;
        #1;
        check("t4_drop_sat", drop_count, 8'hFF);
        check("t4_ber_sat", ber_count, 8'hFF);
        tick(1);
        check("t4_hex0", hex0_d, 7'h71);
        check("t4_hex1", hex1_d, 7'h71);
        check("t4_lanes_up", link_up, 4'b0111);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_drop_clr", drop_count, 0);
        check("t4_ber_clr", ber_count, 0);
        tick(1);
        check("t4_hex0_clr", hex0_d, 7'h3F);

        // 5: clear coincident with a drop on lane 0
        sel = 2'd0;
        rx_block_lock[0] = 1'b0;
        tick(3);
        check("t5_pre_drop", drop_count, 1);
        rx_block_lock[0] = 1'b1;
        tick(19);
        check("t5_relinked", link_up[0], 1);
        rx_block_lock[0] = 1'b0;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t5_clear_wins", drop_count, 0);
        check("t5_link_fell", link_up[0], 0);

        // 6: all lanes up with 5 drops, distinct ber counts, then async reset
        rx_block_lock = 4'h0;
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j <= i; j++) begin
                rx_hi_ber[i] = 1'b1;
                tick(1);
                rx_hi_ber[i] = 1'b0;
                tick(1);
            end
        end
        tick(3);
        for (int k = 0; k < 5; k++) begin
            rx_block_lock = 4'hF;
            tick(19);
            rx_block_lock = 4'h0;
            tick(3);
        end
        rx_block_lock = 4'hF;
        tick(19);
        check("t6_all_up", link_up, 4'hF);
        for (int v = 0; v < 4; v++) begin
            sel = vecs[v].sel;
            tick(1);
            check($sformatf("t6_drop_l%0d", v), drop_count, vecs[v].drop);
            check($sformatf("t6_ber_l%0d", v), ber_count, vecs[v].ber);
            check($sformatf("t6_hex0_l%0d", v), hex0_d, vecs[v].hex0);
            check($sformatf("t6_hex1_l%0d", v), hex1_d, vecs[v].hex1);
            check($sformatf("t6_dp_l%0d", v), hex_dp, vecs[v].dp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(18);
        check("t6_requal_early", link_up, 4'h0);
        tick(1);
        check("t6_requal", link_up, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
